mul_div_seq: RTL and testbench
==============================

Name: mul_div_seq

Overview:
- Multi-cycle sequencer that time-shares one four_adder instance (4-bit adder/subtractor; cin=1 selects subtract) to perform 4x4 unsigned multiply and 4/4 unsigned restoring divide.
- Sits between the lab's switch/button front end and the display path.
- Accepts one operation per start pulse; returns an 8-bit result with a one-cycle done pulse.

Parameters:
- None. Width is fixed at 4 by the shared adder. The iteration count is fixed at 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  operation request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- op_a  input  4  multiplicand / dividend
- op_b  input  4  multiplier / divisor
- busy  output  1  high in ITER and DONE
- done  output  1  one-cycle pulse; result valid
- result  output  8  mul: product[7:0]; div: {remainder[3:0], quotient[3:0]}
- div_by_zero  output  1  high with done when op=1 and op_b=0; held with result

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0; done=0; result=8'h00; div_by_zero=0; all internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- States are IDLE, ITER, DONE.
- IDLE, start=1 at edge N:
  - capture op, op_a, op_b;
  - cnt<=0;
  - state<=ITER;
  - div_by_zero flag computed and registered.
- IDLE, start=0: stay in IDLE.
- ITER: one iteration per edge, at N+1..N+4. On the edge where cnt==3: result register updated, state<=DONE.
- DONE (between edge N+4 and edge N+5): done=1, busy=1. On the next edge: state<=IDLE, done=0.
- start is ignored while busy=1, including in DONE. The earliest next accept is edge N+6 (first edge with state=IDLE).
- Latency: exactly 4 edges from the accept edge to done going high. Throughput: one operation per 6 cycles.
- result and div_by_zero hold their values until the next operation completes. They are not cleared on accept.
- Multiply (shift-add), registers acc[3:0]=0, mq[3:0]=op_b, m=op_a:
  - Adder inputs are a=acc, b=m, cin=0.
  - If mq[0]=1: {acc,mq} <= {carry, sum, mq[3:1]}.
  - Else: {acc,mq} <= {1'b0, acc, mq[3:1]}.
  - After 4 iterations: result={acc,mq}.
  - Maximum value is 15*15=225; no overflow.
- Divide (restoring), registers rem[3:0]=0, q[3:0]=op_a, d=op_b:
  - Trial value t={rem[2:0], q[3]}; shifted-out bit r4=rem[3].
  - Adder inputs are a=t, b=d, cin=1 (computes t-d); carry=1 means no borrow.
  - If r4|carry: rem<=sum, q<={q[2:0],1}.
  - Else: rem<=t, q<={q[2:0],0}.
  - After 4 iterations: result={rem,q}.
- Divide by zero: no special datapath. The algorithm naturally yields quotient=4'hF and remainder=op_a. div_by_zero=1 marks the result; latency is unchanged.
- The adder is driven from registered state only, so it has no combinational path from start/op_a/op_b. In IDLE and DONE the adder inputs are don't-care.
- Exactly one adder instance. No other arithmetic beyond shifts, muxes and the 2-bit counter.

Test Plan:
- Reset, then op=0, op_a=13, op_b=11, start pulse -> done high exactly 4 edges after accept; result=8'h8F (143); div_by_zero=0; busy high for 5 cycles.
- op=0, op_a=15, op_b=15 -> result=8'hE1 (225). Then op_a=0, op_b=9 -> result=8'h00.
- op=1, op_a=13, op_b=3 -> result=8'h14 (rem 1, quot 4). Then op_a=15, op_b=15 -> 8'h01. Then op_a=2, op_b=7 -> 8'h20.
- op=1, op_a=15, op_b=0 -> result=8'hFF, div_by_zero=1. Next op=0, op_a=2, op_b=3 -> result=8'h06, div_by_zero=0.
- start held high continuously with new operands applied in ITER and DONE -> operands ignored until IDLE. A second operation is accepted at the first IDLE edge; results match the operands present on each accept edge; done pulses are exactly 1 cycle wide.
- Assert rst asynchronously two edges into a multiply -> busy, done and result go to 0 immediately with no done pulse. After release, a fresh 5*5 -> 8'h19.

Source files
------------

// File: rtl/mul_div_seq.sv
// Sequential 4x4 unsigned multiply and 4/4 restoring divide built around one
// shared 4-bit adder/subtractor; one operation per start, fixed 4 iterations.

module four_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  // cin=1 turns the adder into a - b (two's complement), cout=1 means no borrow
  logic [3:0] bx;
  assign bx          = b ^ {4{cin}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};
endmodule

module mul_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t     state;
  logic       op_r;
  logic [3:0] hi;     // acc (mul) or rem (div)
  logic [3:0] lo;     // mq (mul) or q (div)
  logic [3:0] opnd;   // m (mul) or d (div)
  logic [1:0] cnt;
  logic       dbz_r;

  logic [3:0] trial, add_a, sum;
  logic       cout;
  logic [3:0] hi_nxt, lo_nxt;

  assign trial = {hi[2:0], lo[3]};
  assign add_a = op_r ? trial : hi;

  four_adder u_add (
    .a    (add_a),
    .b    (opnd),
    .cin  (op_r),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (!op_r) begin
      if (lo[0]) {hi_nxt, lo_nxt} = {cout, sum, lo[3:1]};
      else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[3:1]};
    end else begin
      // restore by keeping the trial value when the subtract would borrow
      if (hi[3] | cout) begin
        hi_nxt = sum;
        lo_nxt = {lo[2:0], 1'b1};
      end else begin
        hi_nxt = trial;
        lo_nxt = {lo[2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      hi          <= 4'h0;
      lo          <= 4'h0;
      opnd        <= 4'h0;
      cnt         <= 2'd0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 8'h00;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            hi    <= 4'h0;
            lo    <= op ? op_a : op_b;
            opnd  <= op ? op_b : op_a;
            cnt   <= 2'd0;
            dbz_r <= op & (op_b == 4'h0);
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            result      <= {hi_nxt, lo_nxt};
            div_by_zero <= dbz_r;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: expected results queued at stimulus time,
// popped and compared by a monitor when done pulses.

module tb_mul_div_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [3:0] op_a = 4'h0;
  logic [3:0] op_b = 4'h0;
  logic       busy, done, div_by_zero;
  logic [7:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       dbz;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic prev_done = 1'b0;

  mul_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(input logic o, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    if (!o)          r = ia * ib;
    else if (ib == 0) r = ia * 16 + 15;
    else             r = (ia % ib) * 16 + (ia / ib);
    return r[7:0];
  endfunction

  // monitor: pop and compare on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      checks++;
      if (prev_done) begin
        failures++;
        $display("FAIL done_width: done high on consecutive cycles, required 1-cycle pulse");
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding");
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (result !== e.res) begin
          failures++;
          $display("FAIL result: got %h required %h", result, e.res);
        end
        if (div_by_zero !== e.dbz) begin
          failures++;
          $display("FAIL div_by_zero: got %b required %b", div_by_zero, e.dbz);
        end
        if (cyc - e.acc_cyc !== 4) begin
          failures++;
          $display("FAIL latency: got %0d edges required 4", cyc - e.acc_cyc);
        end
      end
    end
    prev_done <= done;
  end

  task automatic push_exp(input logic o, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.res     = model(o, a, b);
    e.dbz     = o && (b == 4'h0);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // issue one op when idle; returns number of cycles busy was observed high
  task automatic run_op(input logic o, input logic [3:0] a, input logic [3:0] b, output int nbusy);
    @(negedge clk);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b0;
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    drain("run_op");
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, result, div_by_zero} !== 11'h0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h dbz=%b required all 0",
               busy, done, result, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int nb;
    run_op(1'b0, 4'd13, 4'd11, nb);
    checks++;
    if (nb !== 5) begin
      failures++;
      $display("FAIL busy_cycles: got %0d required 5", nb);
    end
    run_op(1'b0, 4'd15, 4'd15, nb);
    run_op(1'b0, 4'd0,  4'd9,  nb);
  endtask

  task automatic test_div();
    int nb;
    run_op(1'b1, 4'd13, 4'd3,  nb);
    run_op(1'b1, 4'd15, 4'd15, nb);
    run_op(1'b1, 4'd2,  4'd7,  nb);
  endtask

  task automatic test_div_zero();
    int nb;
    run_op(1'b1, 4'd15, 4'd0, nb);
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 8'hFF || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_hold: got result=%h dbz=%b required ff/1", result, div_by_zero);
    end
    run_op(1'b0, 4'd2, 4'd3, nb);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    start = 1'b1; op = 1'b0; op_a = 4'd7; op_b = 4'd9;
    push_exp(1'b0, 4'd7, 4'd9);
    @(negedge clk);
    n = 0;
    // scribble operands while busy; they must be ignored
    while (busy && n < 20) begin
      op = ~op; op_a = op_a + 4'd5; op_b = op_b + 4'd3;
      n++;
      @(negedge clk);
    end
    op = 1'b1; op_a = 4'd14; op_b = 4'd4;
    push_exp(1'b1, 4'd14, 4'd4);
    @(negedge clk);
    op_a = 4'd1; op_b = 4'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_async_reset();
    int nb;
    @(negedge clk);
    start = 1'b1; op = 1'b0; op_a = 4'd13; op_b = 4'd11;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h required 0/0/00", busy, done, result);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done: got done=%b required 0", done);
      end
    end
    rst = 1'b0;
    run_op(1'b0, 4'd5, 4'd5, nb);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
